card_dealer: RTL



---
 rtl/card_dealer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/card_dealer.sv
// Write-side dealer: draws LFSR cards, rejects bad/duplicate ones,
// writes the hand. Optional CARD_INJECT_EN adds inj_valid/inj_card.
module card_dealer #(
  parameter int          HAND_SIZE    = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          FULL_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic        hand_full,
`ifdef CARD_INJECT_EN
  input  logic        inj_valid,
  input  logic [5:0]  inj_card,
`endif
  output logic        we,
  output logic [2:0]  waddr,
  output logic [5:0]  card_in,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int TW =
    (FULL_TIMEOUT > 1) ? $clog2(FULL_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    CHECK,
    WRITE,
    WAIT_FULL,
    DONE,
    ERR
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nx;
  logic [5:0]    cand;
  logic [5:0]    cand_nx;
  logic [2:0]    count;
  logic [5:0]    dealt [HAND_SIZE];
  logic [TW-1:0] timer;
  logic          rank_ok;
  logic          dup;
  logic          accept;
  logic          last_wr;
  logic          tmo;

  // Galois right-shift LFSR step and candidate source
  always_comb begin
    lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
`ifdef CARD_INJECT_EN
    cand_nx = inj_valid ? inj_card : lfsr_nx[5:0];
`else
    cand_nx = lfsr_nx[5:0];
`endif
  end

  // Candidate acceptance: valid rank and not already in this hand
  always_comb begin
    rank_ok = (cand[3:0] >= 4'd2) && (cand[3:0] <= 4'd14);
    dup     = 1'b0;
    for (int i = 0; i < HAND_SIZE; i++) begin
      if ((3'(i) < count) && (dealt[i] == cand)) dup = 1'b1;
    end
    accept  = rank_ok && !dup;
    last_wr = (count + 3'd1) == 3'(HAND_SIZE);
    tmo     = timer == TW'(FULL_TIMEOUT - 1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (seed_load)  state_nx = IDLE;
        else if (start) state_nx = hand_full ? ERR : DRAW;
      end
      DRAW:  state_nx = CHECK;
      CHECK: state_nx = accept ? WRITE : DRAW;
      WRITE: state_nx = last_wr ? WAIT_FULL : DRAW;
      WAIT_FULL: begin
        if (hand_full) state_nx = DONE;
        else if (tmo)  state_nx = ERR;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: LFSR, candidate, hand memory, write bus, timer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr    <= LFSR_SEED;
      cand    <= '0;
      count   <= '0;
      timer   <= '0;
      waddr   <= '0;
      card_in <= '0;
      for (int i = 0; i < HAND_SIZE; i++) dealt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_load)
            lfsr <= (seed_in == 16'h0) ? LFSR_SEED : seed_in;
          else if (start && !hand_full)
            count <= '0;
        end
        DRAW: begin
          lfsr <= lfsr_nx;
          cand <= cand_nx;
        end
        CHECK: begin
          if (accept) begin
            waddr   <= count;
            card_in <= cand;
          end
        end
        WRITE: begin
          dealt[count] <= cand;
          count        <= count + 3'd1;
          timer        <= '0;
        end
        WAIT_FULL: timer <= timer + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    we    = state == WRITE;
    busy  = state != IDLE;
    done  = state == DONE;
    error = state == ERR;
  end

endmodule
